// File: rtl/dma_read_responder.sv
// Single-word DMA read responder between device initiators and memory.
// Optional odd-parity checking on memory data: define DMA_RESP_PARITY_EN.
module dma_read_responder #(
    parameter int MEM_TIMEOUT = 127,
    parameter int AWIDTH      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              devREQI,
    input  logic [35:0]       devADDRI,
    output logic              devACKO,
    output logic [35:0]       devDATAO,
    output logic              memREQO,
    output logic [AWIDTH-1:0] memADDRO,
    input  logic              memACKI,
    input  logic [35:0]       memDATAI,
    input  logic              clrNXM,
    output logic              nxmFLAG,
    output logic [15:0]       xferCOUNT,
    output logic              busy
`ifdef DMA_RESP_PARITY_EN
    ,
    input  logic              memPARI,
    output logic              perrFLAG
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEMWAIT = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_timer, w_timer_nxt;
    logic              r_memreq, w_memreq_nxt;
    logic              r_ack, w_ack_nxt;
    logic [35:0]       r_data, w_data_nxt;
    logic [AWIDTH-1:0] r_addr, w_addr_nxt;
    logic              r_nxm, w_nxm_nxt;
    logic [15:0]       r_count, w_count_nxt;
    logic              r_busy;
    logic              w_nxm_set;

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_memreq_nxt = r_memreq;
        w_ack_nxt    = r_ack;
        w_data_nxt   = r_data;
        w_addr_nxt   = r_addr;
        w_count_nxt  = r_count;
        w_nxm_set    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (devREQI) begin
                    w_addr_nxt   = devADDRI[AWIDTH-1:0];
                    w_memreq_nxt = 1'b1;
                    w_timer_nxt  = TMO;
                    w_state_nxt  = MEMWAIT;
                end
            end
            MEMWAIT: begin
                if (!devREQI) begin
                    w_memreq_nxt = 1'b0;
                    w_state_nxt  = IDLE;
                end else if (memACKI) begin
                    w_data_nxt   = memDATAI;
                    w_memreq_nxt = 1'b0;
                    w_ack_nxt    = 1'b1;
                    w_state_nxt  = ACK;
                end else if (r_timer == 8'd0) begin
                    w_memreq_nxt = 1'b0;
                    w_nxm_set    = 1'b1;
                    w_state_nxt  = RELEASE;
                end else begin
                    w_timer_nxt = r_timer - 8'd1;
                end
            end
            ACK: begin
                w_ack_nxt   = 1'b0;
                w_count_nxt = r_count + 16'd1;
                w_state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!devREQI) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // A new NXM outranks a simultaneous clear.
        w_nxm_nxt = r_nxm;
        if (clrNXM) begin
            w_nxm_nxt = 1'b0;
        end
        if (w_nxm_set) begin
            w_nxm_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_timer  <= TMO;
            r_memreq <= 1'b0;
            r_ack    <= 1'b0;
            r_data   <= '0;
            r_addr   <= '0;
            r_nxm    <= 1'b0;
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_memreq <= w_memreq_nxt;
            r_ack    <= w_ack_nxt;
            r_data   <= w_data_nxt;
            r_addr   <= w_addr_nxt;
            r_nxm    <= w_nxm_nxt;
            r_count  <= w_count_nxt;
            r_busy   <= (w_state_nxt != IDLE);
        end
    end

`ifdef DMA_RESP_PARITY_EN
    logic r_perr;
    logic w_perr_set;

    assign w_perr_set = (r_state == MEMWAIT) && devREQI && memACKI
                        && ((^memDATAI ^ memPARI) != 1'b1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perr <= 1'b0;
        end else if (w_perr_set) begin
            r_perr <= 1'b1;
        end else if (clrNXM) begin
            r_perr <= 1'b0;
        end
    end

    assign perrFLAG = r_perr;
`endif

    assign devACKO   = r_ack;
    assign devDATAO  = r_data;
    assign memREQO   = r_memreq;
    assign memADDRO  = r_addr;
    assign nxmFLAG   = r_nxm;
    assign xferCOUNT = r_count;
    assign busy      = r_busy;

endmodule

// File: doc/dma_read_responder.md
Name: dma_read_responder

Overview:
- Bus-side responder for single-word device DMA reads, e.g. from the LP20 line-printer controller.
- Accepts a device read request, performs one memory read, and returns the data with a one-cycle acknowledge.
- Withholds the acknowledge on memory non-existence so the requesting device's own acknowledge-timeout logic fires.
- Sits between device DMA initiators and the memory controller port.

Parameters:
- MEM_TIMEOUT, 127: cycles to wait for memACKI before declaring non-existent memory (NXM); 8-bit counter, legal range 1..255.
- AWIDTH, 20: memory word-address width taken from devADDRI[AWIDTH-1:0].

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- devREQI  input  1  device read request; held high until ACK or device timeout
- devADDRI  input  36  device read address; bits [AWIDTH-1:0] used
- devACKO  output  1  one-cycle acknowledge; devDATAO valid this cycle
- devDATAO  output  36  read data; held until next memory data capture
- memREQO  output  1  memory read request; level, held until memACKI
- memADDRO  output  AWIDTH  latched memory address
- memACKI  input  1  memory acknowledge; memDATAI valid this cycle
- memDATAI  input  36  memory read data
- clrNXM  input  1  clears the sticky NXM flag
- nxmFLAG  output  1  sticky non-existent-memory flag
- xferCOUNT  output  16  completed-transfer counter; wraps 0xFFFF->0
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst low, async) values: devACKO=0, devDATAO=0, memREQO=0, memADDRO=0, nxmFLAG=0, xferCOUNT=0, timer=MEM_TIMEOUT, state=IDLE.
- All outputs are registered.
- States: IDLE, MEMWAIT, ACK, RELEASE.
- IDLE: on devREQI=1:
  - memADDRO<=devADDRI[AWIDTH-1:0], memREQO<=1, timer<=MEM_TIMEOUT -> MEMWAIT.
  - memREQO is high one cycle after the devREQI rising edge.
- MEMWAIT, evaluated in priority order:
  - (a) devREQI=0 (initiator abandoned the request): memREQO<=0 -> IDLE. No ACK, no count, no NXM.
  - (b) memACKI=1: devDATAO<=memDATAI, memREQO<=0, devACKO<=1 -> ACK.
  - (c) timer==0: memREQO<=0, nxmFLAG<=1 -> RELEASE. No ACK.
  - (d) otherwise timer decrements.
- ACK: devACKO<=0, xferCOUNT<=xferCOUNT+1 (modulo 2^16) -> RELEASE.
  - devACKO is therefore exactly one cycle wide.
- RELEASE: wait for devREQI=0, then -> IDLE.
  - Guarantees one response per request; a request held high is never serviced twice.
- Latency: memACKI sampled in cycle N -> devACKO high in cycle N+1.
  - Minimum devREQI-to-devACKO latency is 3 cycles with zero-wait memory.
- clrNXM and the NXM set condition in the same cycle: set wins.
- clrNXM works in any state and does not affect the state machine.
- Reset mid-transaction: memREQO and devACKO drop immediately (async); no partial count.
- devADDRI is sampled only in IDLE; later changes are ignored until the next request.

Optional Feature:
- Macro: DMA_RESP_PARITY_EN.
- When defined:
  - Adds input memPARI (1 bit, odd parity over memDATAI) and output perrFLAG (sticky, reset 0, cleared by clrNXM).
  - On memACKI, if ^memDATAI ^ memPARI != 1, perrFLAG<=1.
  - The ACK is still returned and the data still passed.
- When undefined: neither port exists and no parity logic is generated.

Test Plan:
- Basic read: devREQI=1, devADDRI=0o1234; memACKI after 2 cycles with 0o123456701234 -> memADDRO=0x29C, devACKO one cycle, devDATAO=0o123456701234, xferCOUNT=1, nxmFLAG=0.
- Held request: devREQI held high 20 cycles after ACK -> exactly one devACKO and one memREQO transaction; new service only after devREQI falls then rises.
- NXM: MEM_TIMEOUT=127, memACKI never asserted -> memREQO drops after 128 cycles in MEMWAIT, nxmFLAG=1, devACKO never asserted; clrNXM pulse -> nxmFLAG=0.
- Abandon: devREQI drops while in MEMWAIT at timer=50 -> memREQO=0 next cycle, state IDLE, xferCOUNT unchanged, nxmFLAG=0.
- Wrap and async reset: preload 65535 transfers -> next ACK gives xferCOUNT=0; assert rst mid-MEMWAIT -> memREQO=0 immediately, all outputs at reset values.
- Parity (DMA_RESP_PARITY_EN): memDATAI=1, memPARI=1 (even total) -> perrFLAG=1 with devACKO still pulsed; memPARI=0 -> perrFLAG stays 0.
